trs_video_capture: RTL and testbench

Receiver for the native TRS-80 Model I video signal. Samples the 1-bit pixel stream with its HSYNC/VSYNC on the 100 MHz system clock. Recovers the 384x192 active raster, packs it into bytes and emits a byte-wide write stream. A downstream frame-buffer RAM can then be read back or redisplayed by the VGA path.

---
 rtl/trs_video_capture.sv | 230 +++++++++++++++++++++++
 tb/tb_trs_video_capture.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trs_video_capture.sv
// TRS-80 Model I video capture: syncs VID/HSYNC/VSYNC, recovers the active raster, emits packed byte writes (bit 7 = leftmost).
// Edge detect 3 clocks after the pins; no backpressure. Define VIDCAP_MAJORITY_EN for a 2-of-3 vote per pixel (cap_we one clock later).
module trs_video_capture #(
    parameter int CLKS_PER_PIXEL = 10,
    parameter int H_OFFSET       = 40,
    parameter int V_OFFSET       = 24,
    parameter int ACTIVE_W       = 384,
    parameter int ACTIVE_H       = 192
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cap_en,
    input  logic        VID_IN,
    input  logic        HSYNC_IN,
    input  logic        VSYNC_IN,
    output logic        cap_we,
    output logic [13:0] cap_addr,
    output logic [7:0]  cap_data,
    output logic        frame_done,
    output logic        sync_err,
    output logic        locked
);

    localparam int BPL       = ACTIVE_W / 8;
    localparam int LAST_ADDR = ACTIVE_W * ACTIVE_H / 8 - 1;
    localparam int DIV_W     = $clog2(CLKS_PER_PIXEL);
    localparam int PIX_W     = $clog2(ACTIVE_W);
    localparam int LINE_W    = $clog2(ACTIVE_H + 1);
    localparam int VCNT_W    = $clog2(V_OFFSET + 2);
    localparam int HCNT_W    = $clog2(H_OFFSET + 2);

    typedef enum logic [2:0] {IDLE, VSKIP, HWAIT, HSKIP, ACTIVE, DONE} state_t;

    state_t              state, state_nxt;
    logic [1:0]          vid_sr;
    logic [2:0]          hs_sr, vs_sr;
    logic                vid_s, vs_s;
    logic                hs_fall, hs_rise, vs_fall, vs_rise;
    logic [DIV_W-1:0]    div;
    logic                tick, pix_bit;
    logic [HCNT_W-1:0]   hcnt;
    logic [VCNT_W-1:0]   vcnt;
    logic [PIX_W-1:0]    pix_cnt;
    logic [LINE_W-1:0]   line_cnt;
    logic [13:0]         line_base;
    logic [7:0]          shreg;
    logic                frame_err;
    logic                last_line, err_line, err_frame, byte_done, line_end;

    assign vid_s   = vid_sr[1];
    assign vs_s    = vs_sr[1];
    assign hs_fall = hs_sr[2] & ~hs_sr[1];
    assign hs_rise = ~hs_sr[2] & hs_sr[1];
    assign vs_fall = vs_sr[2] & ~vs_sr[1];
    assign vs_rise = ~vs_sr[2] & vs_sr[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            vid_sr <= '0;
            hs_sr  <= '0;
            vs_sr  <= '0;
        end else begin
            vid_sr <= {vid_sr[0], VID_IN};
            hs_sr  <= {hs_sr[1:0], HSYNC_IN};
            vs_sr  <= {vs_sr[1:0], VSYNC_IN};
        end
    end

    // Divider phase is only anchored at the line start; no drift correction within a line.
    always_ff @(posedge clk) begin
        if (reset || hs_fall || div == DIV_W'(CLKS_PER_PIXEL - 1))
            div <= '0;
        else
            div <= div + 1'b1;
    end

`ifdef VIDCAP_MAJORITY_EN
    logic samp_a, samp_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            samp_a <= 1'b0;
            samp_b <= 1'b0;
        end else begin
            if (div == DIV_W'(CLKS_PER_PIXEL / 2 - 1)) samp_a <= vid_s;
            if (div == DIV_W'(CLKS_PER_PIXEL / 2))     samp_b <= vid_s;
        end
    end

    // The third sample is taken live on the tick itself.
    assign tick    = (div == DIV_W'(CLKS_PER_PIXEL / 2 + 1));
    assign pix_bit = (samp_a & samp_b) | (samp_a & vid_s) | (samp_b & vid_s);
`else
    assign tick    = (div == DIV_W'(CLKS_PER_PIXEL / 2));
    assign pix_bit = vid_s;
`endif

    assign last_line = (line_cnt == LINE_W'(ACTIVE_H - 1));

    always_comb begin
        state_nxt = state;
        err_line  = 1'b0;
        err_frame = 1'b0;
        byte_done = 1'b0;
        line_end  = 1'b0;
        case (state)
            IDLE: begin
                if (vs_fall && cap_en) state_nxt = VSKIP;
            end
            VSKIP: begin
                if (!vs_s && hs_fall && vcnt == VCNT_W'(V_OFFSET - 1)) state_nxt = HWAIT;
            end
            HWAIT: begin
                if (vs_rise) begin
                    err_frame = 1'b1;
                    state_nxt = IDLE;
                end else if (hs_fall) begin
                    state_nxt = HSKIP;
                end
            end
            HSKIP: begin
                if (vs_rise) begin
                    err_frame = 1'b1;
                    state_nxt = IDLE;
                end else if (tick && hcnt == HCNT_W'(H_OFFSET - 1)) begin
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    err_frame = 1'b1;
                    state_nxt = IDLE;
                end else if (hs_rise) begin
                    err_line  = 1'b1;
                    state_nxt = last_line ? DONE : HWAIT;
                end else if (tick) begin
                    byte_done = (pix_cnt[2:0] == 3'd7);
                    if (pix_cnt == PIX_W'(ACTIVE_W - 1)) begin
                        line_end  = 1'b1;
                        state_nxt = last_line ? DONE : HWAIT;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hcnt       <= '0;
            vcnt       <= '0;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            line_base  <= '0;
            shreg      <= '0;
            frame_err  <= 1'b0;
            cap_we     <= 1'b0;
            cap_addr   <= '0;
            cap_data   <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            locked     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cap_we     <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            if (cap_we)
                cap_addr <= (cap_addr == 14'(LAST_ADDR)) ? '0 : cap_addr + 1'b1;
            case (state)
                IDLE: begin
                    if (vs_fall && cap_en) begin
                        vcnt      <= '0;
                        line_cnt  <= '0;
                        line_base <= '0;
                        cap_addr  <= '0;
                        frame_err <= 1'b0;
                    end
                end
                VSKIP: begin
                    if (vs_s)
                        vcnt <= '0;
                    else if (hs_fall)
                        vcnt <= vcnt + 1'b1;
                end
                HWAIT: begin
                    if (hs_fall) begin
                        hcnt    <= '0;
                        pix_cnt <= '0;
                    end
                end
                HSKIP: begin
                    if (tick) hcnt <= hcnt + 1'b1;
                end
                ACTIVE: begin
                    if (err_line) begin
                        // Partial byte is dropped; skip the rest of this line's addresses.
                        line_cnt  <= line_cnt + 1'b1;
                        line_base <= line_base + 14'(BPL);
                        cap_addr  <= last_line ? '0 : line_base + 14'(BPL);
                    end else if (!err_frame && tick) begin
                        shreg   <= {shreg[6:0], pix_bit};
                        pix_cnt <= pix_cnt + 1'b1;
                        if (byte_done) begin
                            cap_we   <= 1'b1;
                            cap_data <= {shreg[6:0], pix_bit};
                        end
                        if (line_end) begin
                            line_cnt  <= line_cnt + 1'b1;
                            line_base <= line_base + 14'(BPL);
                        end
                    end
                end
                DONE: begin
                    frame_done <= 1'b1;
                    if (!frame_err) locked <= 1'b1;
                end
                default: ;
            endcase
            if (err_line || err_frame) begin
                sync_err  <= 1'b1;
                locked    <= 1'b0;
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trs_video_capture.sv
// Bench for trs_video_capture: drives synthetic TRS-80 frames from a pixel image and scoreboards the byte writes.
module tb_trs_video_capture;

    localparam int CPP    = 4;
    localparam int HOFF   = 4;
    localparam int VOFF   = 2;
    localparam int AW     = 32;
    localparam int AH     = 8;
    localparam int BPL    = AW / 8;
    localparam int NBYTES = AW * AH / 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cap_en = 1'b1;
    logic        VID_IN = 1'b0;
    logic        HSYNC_IN = 1'b0;
    logic        VSYNC_IN = 1'b0;
    logic        cap_we;
    logic [13:0] cap_addr;
    logic [7:0]  cap_data;
    logic        frame_done;
    logic        sync_err;
    logic        locked;

    trs_video_capture #(
        .CLKS_PER_PIXEL(CPP),
        .H_OFFSET      (HOFF),
        .V_OFFSET      (VOFF),
        .ACTIVE_W      (AW),
        .ACTIVE_H      (AH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cap_en    (cap_en),
        .VID_IN    (VID_IN),
        .HSYNC_IN  (HSYNC_IN),
        .VSYNC_IN  (VSYNC_IN),
        .cap_we    (cap_we),
        .cap_addr  (cap_addr),
        .cap_data  (cap_data),
        .frame_done(frame_done),
        .sync_err  (sync_err),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    bit         img [AH][AW];
    logic [7:0] got_mem [NBYTES];
    int         wr_hits [NBYTES];
    int         wr_total, fd_cnt, se_cnt, first_addr, max_addr, mon_a;
    logic       prev_we = 1'b0;
    bit         glitch_flip;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (frame_done) begin
                expect_eq("frame_done_after_last_we", 32'(prev_we), 32'd1);
                fd_cnt++;
            end
            if (sync_err) se_cnt++;
            if (cap_we) begin
                mon_a = int'(cap_addr);
                if (first_addr < 0) first_addr = mon_a;
                if (mon_a > max_addr) max_addr = mon_a;
                if (mon_a < NBYTES) begin
                    got_mem[mon_a] = cap_data;
                    wr_hits[mon_a] = wr_hits[mon_a] + 1;
                end
                wr_total++;
            end
        end
        prev_we = cap_we;
    end

    task automatic clear_sb();
        for (int a = 0; a < NBYTES; a++) begin
            got_mem[a] = '0;
            wr_hits[a] = 0;
        end
        wr_total   = 0;
        fd_cnt     = 0;
        se_cnt     = 0;
        first_addr = -1;
        max_addr   = -1;
    endtask

    task automatic drive(input logic v, input logic h, input logic vs);
        @(posedge clk);
        #1;
        VID_IN   = v;
        HSYNC_IN = h;
        VSYNC_IN = vs;
    endtask

    // Pixel n of a line occupies clocks 4n+1..4n+4 after the HSYNC fall; skip and tail pixels are random.
    task automatic send_line(input int ln, input bit active, input int short_px, input bit glitch);
        bit b;
        bit in_act;
        for (int i = 0; i < 3 * CPP; i++) drive(1'($urandom), 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        for (int n = 0; n < HOFF + AW + 2; n++) begin
            in_act = active && n >= HOFF && n < HOFF + AW;
            if (in_act && short_px >= 0 && n >= HOFF + short_px) return;
            b = in_act ? img[ln][n - HOFF] : 1'($urandom);
            for (int c = 0; c < CPP; c++)
                drive((glitch && in_act && c == CPP / 2) ? ~b : b, 1'b0, 1'b0);
        end
    endtask

    task automatic vsync_pulse();
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++)  drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int nlines, input int short_ln, input int short_px, input bit glitch);
        vsync_pulse();
        for (int l = 0; l < VOFF; l++) send_line(0, 1'b0, -1, 1'b0);
        for (int l = 0; l < nlines; l++)
            send_line(l, 1'b1, (l == short_ln) ? short_px : -1, glitch);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic fill_aa55();
        logic [7:0] p;
        for (int l = 0; l < AH; l++)
            for (int x = 0; x < AW; x++) begin
                p = ((x / 8) % 2 == 0) ? 8'hAA : 8'h55;
                img[l][x] = p[7 - (x % 8)];
            end
    endtask

    task automatic fill_line0();
        for (int l = 0; l < AH; l++)
            for (int x = 0; x < AW; x++) img[l][x] = (l == 0);
    endtask

    task automatic fill_random();
        for (int l = 0; l < AH; l++)
            for (int x = 0; x < AW; x++) img[l][x] = 1'($urandom);
    endtask

    // Expected memory image: bytes of lines < exp_lines, minus the short line from its partial byte onward.
    task automatic verify_frame(input string tag, input int exp_lines, input int short_ln, input int short_px,
                                input bit flip, input int exp_fd, input int exp_se, input logic exp_lock);
        int         exp_wr;
        int         ln;
        int         bi;
        bit         wr;
        logic [7:0] eb;
        exp_wr = 0;
        for (int a = 0; a < NBYTES; a++) begin
            ln = a / BPL;
            bi = a % BPL;
            wr = (ln < exp_lines) && !(ln == short_ln && bi >= short_px / 8);
            expect_eq($sformatf("%s_hits[%0d]", tag, a), 32'(wr_hits[a]), 32'(wr));
            if (wr) begin
                exp_wr++;
                for (int k = 0; k < 8; k++) eb[7 - k] = img[ln][8 * bi + k] ^ flip;
                expect_eq($sformatf("%s_data[%0d]", tag, a), 32'(got_mem[a]), 32'(eb));
            end
        end
        expect_eq({tag, "_writes"}, 32'(wr_total), 32'(exp_wr));
        expect_eq({tag, "_frame_done"}, 32'(fd_cnt), 32'(exp_fd));
        expect_eq({tag, "_sync_err"}, 32'(se_cnt), 32'(exp_se));
        expect_eq({tag, "_locked"}, 32'(locked), 32'(exp_lock));
        expect_eq({tag, "_addr_bound"}, 32'(max_addr < NBYTES), 32'd1);
        if (exp_lines > 0) expect_eq({tag, "_first_addr"}, 32'(first_addr), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        expect_eq({tag, "_cap_we"}, 32'(cap_we), 32'd0);
        expect_eq({tag, "_cap_addr"}, 32'(cap_addr), 32'd0);
        expect_eq({tag, "_cap_data"}, 32'(cap_data), 32'd0);
        expect_eq({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        expect_eq({tag, "_sync_err"}, 32'(sync_err), 32'd0);
        expect_eq({tag, "_locked"}, 32'(locked), 32'd0);
    endtask

    initial begin
        clear_sb();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        fill_aa55();
        clear_sb();
        send_frame(AH, -1, 0, 1'b0);
        verify_frame("aa55", AH, -1, 0, 1'b0, 1, 0, 1'b1);
        expect_eq("aa55_addr0", 32'(got_mem[0]), 32'h0AA);
        expect_eq("aa55_addr1", 32'(got_mem[1]), 32'h055);
        expect_eq("aa55_last_addr", 32'(max_addr), 32'(NBYTES - 1));

        fill_line0();
        clear_sb();
        send_frame(AH, -1, 0, 1'b0);
        verify_frame("line0_lit", AH, -1, 0, 1'b0, 1, 0, 1'b1);

        for (int r = 0; r < 2; r++) begin
            fill_random();
            clear_sb();
            send_frame(AH, -1, 0, 1'b0);
            verify_frame($sformatf("rand%0d", r), AH, -1, 0, 1'b0, 1, 0, 1'b1);
        end

        fill_random();
        clear_sb();
        send_frame(AH, 5, 13, 1'b0);
        verify_frame("short_line", AH, 5, 13, 1'b0, 1, 1, 1'b0);

        fill_random();
        clear_sb();
        send_frame(4, -1, 0, 1'b0);
        vsync_pulse();
        verify_frame("short_frame", 4, -1, 0, 1'b0, 0, 1, 1'b0);
        fill_random();
        clear_sb();
        send_frame(AH, -1, 0, 1'b0);
        verify_frame("recover", AH, -1, 0, 1'b0, 1, 0, 1'b1);

        fill_random();
        fork
            send_frame(AH, -1, 0, 1'b0);
            begin
                repeat (700) @(posedge clk);
                #2 reset = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check_reset_outputs("mid_reset");
                @(posedge clk);
                #2 reset = 1'b0;
            end
        join
        fill_random();
        clear_sb();
        send_frame(AH, -1, 0, 1'b0);
        verify_frame("after_reset", AH, -1, 0, 1'b0, 1, 0, 1'b1);

        fill_random();
        clear_sb();
        fork
            send_frame(AH, -1, 0, 1'b0);
            begin
                repeat (700) @(posedge clk);
                #2 cap_en = 1'b0;
            end
        join
        verify_frame("en_drop", AH, -1, 0, 1'b0, 1, 0, 1'b1);
        fill_random();
        clear_sb();
        send_frame(AH, -1, 0, 1'b0);
        verify_frame("en_off", 0, -1, 0, 1'b0, 0, 0, 1'b1);
        cap_en = 1'b1;

`ifdef VIDCAP_MAJORITY_EN
        glitch_flip = 1'b0;
`else
        glitch_flip = 1'b1;
`endif
        fill_aa55();
        clear_sb();
        send_frame(AH, -1, 0, 1'b1);
        verify_frame("glitch", AH, -1, 0, glitch_flip, 1, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
